conv_tile_sched: RTL and testbench
==================================

Name: conv_tile_sched

Overview:
Sequencer that walks a greyscale image stored in a 16-bit-wide pixel memory and feeds the conv/pool engine one 4x4 tile at a time. Tiles are taken with stride 2 in both dimensions. For each tile the block fetches 8 words, packs them into the engine's 128-bit tile bus, pulses the engine read enable, and waits for the engine's write-enable (done) pulse before advancing. Sits between the host control registers and the conv_pool engine; kernels and the output memory connect to the engine directly.

Parameters:
TIMEOUT, 64, max cycles in WAIT for eng_done before error abort (width = clog2(TIMEOUT)+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  cancel the frame; effective in any state
img_w  in  8  image width in pixels; even, >=4
img_h  in  8  image height in pixels; even, >=4
img_base  in  16  word address of pixel (0,0)
shift_cfg  in  2  engine shift, latched on accepted start
busy  out  1  frame in progress
done  out  1  1-cycle pulse, frame complete
err  out  1  sticky error flag
err_code  out  2  01 timeout, 10 bad config
tile_count  out  16  tiles completed this frame
mem_re  out  1  pixel memory read enable
mem_addr  out  16  pixel memory word address
mem_rdata  in  16  read data, valid 1 cycle after mem_re; [7:0]=left pixel, [15:8]=right pixel
eng_re  out  1  engine input_re, 1-cycle pulse
eng_addr  out  16  engine input_addr = tile index
eng_image  out  128  engine tile bus
eng_shift  out  2  engine shift
eng_done  in  1  engine output_we_0 pulse

Behaviour:
- Reset (rst=0 at clk): state IDLE. All outputs 0, including eng_image, tile_count, err, err_code.
- States: IDLE, FETCH, ISSUE, WAIT, NEXT, DONE.
- IDLE: on start with valid config, go to FETCH. Same cycle: latch cfg and shift_cfg; clear err, err_code, tile_count, tile index, tx, ty; set busy=1 from the next cycle. Invalid config (img_w or img_h odd or <4): err=1, err_code=10, stay IDLE, busy stays 0. start while not in IDLE is ignored.
- FETCH: 9 cycles, fetch counter k=0..8.
  - k=0..7: mem_re=1, mem_addr = base + (ty + (k>>1))*(img_w/2) + tx/2 + (k&1).
  - Read k data arrives one cycle later and is written to eng_image[r*32+c*8 +:8] with r=k>>1, c=2*(k&1). The low byte goes to column c, the high byte to column c+1.
  - k=8: drain only, mem_re=0. Then go to ISSUE.
  - Running row-pointer arithmetic is allowed in place of the multiply; the address result must be identical.
- ISSUE: eng_re=1 for exactly 1 cycle, eng_addr = tile index. Then go to WAIT with the timer cleared.
- WAIT: timer increments each cycle.
  - eng_done=1: go to NEXT; tile_count increments.
  - Timer reaches TIMEOUT without eng_done: err=1, err_code=01, go to IDLE, busy=0, no done pulse.
- NEXT (1 cycle):
  - If tx==img_w-4 and ty==img_h-4: go to DONE.
  - Else if tx==img_w-4: tx=0, ty+=2.
  - Else: tx+=2.
  - Tile index increments; go to FETCH.
- DONE: done=1 for 1 cycle, busy=0 from the next cycle, go to IDLE.
- eng_image and eng_shift hold stable from the end of FETCH through ISSUE and WAIT. eng_image is updated only by FETCH captures.
- eng_done outside WAIT is ignored; it does not count and does not advance state.
- abort: next state IDLE from any state.
  - mem_re and eng_re are 0 from the next cycle.
  - busy goes to 0; no done pulse; err unchanged; tile_count holds.
  - abort beats start and eng_done in the same cycle.
- Frame tiles = ((img_w-4)/2+1)*((img_h-4)/2+1). Address arithmetic is 16-bit and wraps modulo 2^16.

Test Plan:
- 4x4 image, base=0x0100, mem words 0x0100..0x0107, eng_done 5 cycles after eng_re -> reads 0x0100..0x0107 in order; one eng_re with eng_addr=0; then done pulse; tile_count=1.
- 8x6 image, base=0 -> 6 tiles, eng_addr 0..5.
  - Tile 0 reads 0,1,4,5,8,9,12,13.
  - Tile 1 reads 1,2,5,6,9,10,13,14.
  - Tile 3 reads 8,9,12,13,16,17,20,21.
  - done once; tile_count=6.
- Packing: word k = {8'(2k+1), 8'(2k)} -> eng_image bytes 0..15 = 0x00..0x0F, i.e. byte (r*4+c) = r*4+c.
- eng_done never returned, TIMEOUT=64 -> 64 cycles after ISSUE: err=1, err_code=01, busy=0, no done pulse. Next valid start clears err.
- img_w=5 start -> err_code=10, busy stays 0, mem_re never asserted.
- abort during FETCH k=3 -> mem_re=0 next cycle, IDLE, no eng_re. start asserted while busy and spurious eng_done in IDLE -> no effect.

Source files
------------

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks a greyscale image held in 16-bit pixel memory and
// feeds the conv/pool engine one 4x4 tile at a time, stride 2 in x and y.
// Each tile takes 8 word reads packed into a 128-bit bus, then one engine
// read-enable pulse, then a wait for the engine's done pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, abort             frame control (abort wins over everything)
//   img_w, img_h, img_base   frame geometry, latched on accepted start
//   shift_cfg                engine shift, latched on accepted start
//   busy, done, err,
//   err_code, tile_count     frame status
//   mem_re, mem_addr,
//   mem_rdata                pixel memory read port (1-cycle latency)
//   eng_re, eng_addr,
//   eng_image, eng_shift,
//   eng_done                 conv/pool engine handshake
module conv_tile_sched #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [7:0]   img_w,
  input  logic [7:0]   img_h,
  input  logic [15:0]  img_base,
  input  logic [1:0]   shift_cfg,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [15:0]  tile_count,
  output logic         mem_re,
  output logic [15:0]  mem_addr,
  input  logic [15:0]  mem_rdata,
  output logic         eng_re,
  output logic [15:0]  eng_addr,
  output logic [127:0] eng_image,
  output logic [1:0]   eng_shift,
  input  logic         eng_done
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_e;

  state_e         state_q;
  logic [7:0]     w_q, h_q, tx_q, ty_q;
  logic [15:0]    row_q;       // word address of row ty of the current tile column 0
  logic [15:0]    tile_idx_q;
  logic [3:0]     k_q;
  logic [TW-1:0]  timer_q;

  logic           cfg_ok_c;
  logic           last_col_c, last_row_c;
  logic [7:0]     tx_n_c;
  logic [15:0]    row_n_c, half_w_c, next_tile_addr_c;
  logic [2:0]     slot_c;

  // Next-tile position and its first read address (row pointer, no multiply)
  always_comb begin
    cfg_ok_c         = !img_w[0] && (img_w >= 8'd4) && !img_h[0] && (img_h >= 8'd4);
    half_w_c         = 16'(w_q[7:1]);
    last_col_c       = (tx_q == (w_q - 8'd4));
    last_row_c       = (ty_q == (h_q - 8'd4));
    tx_n_c           = last_col_c ? 8'd0 : (tx_q + 8'd2);
    row_n_c          = last_col_c ? (row_q + 16'(w_q)) : row_q;
    next_tile_addr_c = row_n_c + 16'(tx_n_c[7:1]);
    slot_c           = 3'(k_q - 4'd1);
  end

  // Sequencer: state plus all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      row_q      <= '0;
      tile_idx_q <= '0;
      k_q        <= '0;
      timer_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      tile_count <= '0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      eng_re     <= 1'b0;
      eng_addr   <= '0;
      eng_image  <= '0;
      eng_shift  <= '0;
    end else begin
      done   <= 1'b0;
      eng_re <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        mem_re  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok_c) begin
                state_q    <= S_FETCH;
                w_q        <= img_w;
                h_q        <= img_h;
                eng_shift  <= shift_cfg;
                tx_q       <= '0;
                ty_q       <= '0;
                row_q      <= img_base;
                tile_idx_q <= '0;
                tile_count <= '0;
                err        <= 1'b0;
                err_code   <= '0;
                busy       <= 1'b1;
                k_q        <= '0;
                mem_re     <= 1'b1;
                mem_addr   <= img_base;
              end else begin
                err      <= 1'b1;
                err_code <= 2'b10;
              end
            end
          end
          S_FETCH: begin
            // Data for read k-1 is on mem_rdata; word k-1 covers bytes 2(k-1), 2(k-1)+1
            if (k_q != 4'd0) begin
              eng_image[{slot_c, 4'b0000} +: 16] <= mem_rdata;
            end
            // Even k -> right word of same row; odd k -> left word of next row
            if (k_q < 4'd7) begin
              mem_re   <= 1'b1;
              mem_addr <= k_q[0] ? (mem_addr + half_w_c - 16'd1) : (mem_addr + 16'd1);
            end else begin
              mem_re <= 1'b0;
            end
            k_q <= k_q + 4'd1;
            if (k_q == 4'd8) begin
              state_q  <= S_ISSUE;
              eng_re   <= 1'b1;
              eng_addr <= tile_idx_q;
            end
          end
          S_ISSUE: begin
            state_q <= S_WAIT;
            timer_q <= '0;
          end
          S_WAIT: begin
            if (eng_done) begin
              state_q    <= S_NEXT;
              tile_count <= tile_count + 16'd1;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
              state_q  <= S_IDLE;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_NEXT: begin
            tile_idx_q <= tile_idx_q + 16'd1;
            if (last_col_c && last_row_c) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              tx_q     <= tx_n_c;
              row_q    <= row_n_c;
              if (last_col_c) begin
                ty_q <= ty_q + 8'd2;
              end
              k_q      <= '0;
              mem_re   <= 1'b1;
              mem_addr <= next_tile_addr_c;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
module tb_conv_tile_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort;
  logic [7:0]   img_w, img_h;
  logic [15:0]  img_base;
  logic [1:0]   shift_cfg;
  logic         busy, done, err;
  logic [1:0]   err_code;
  logic [15:0]  tile_count;
  logic         mem_re;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_rdata;
  logic         eng_re;
  logic [15:0]  eng_addr;
  logic [127:0] eng_image;
  logic [1:0]   eng_shift;
  logic         eng_done;

  logic         eng_auto;
  logic         spur_done;
  logic         done_model;
  logic [3:0]   eng_cnt;
  int           done_cnt;
  logic [15:0]  addr_log[$];
  logic [15:0]  eng_log[$];

  int checks = 0;
  int errors = 0;

  conv_tile_sched #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_w(img_w), .img_h(img_h), .img_base(img_base), .shift_cfg(shift_cfg),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .tile_count(tile_count),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .eng_re(eng_re), .eng_addr(eng_addr), .eng_image(eng_image),
    .eng_shift(eng_shift), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  assign eng_done = done_model | spur_done;

  // Pixel memory: word a holds {2a+1, 2a} in its byte lanes
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= {8'(2 * mem_addr + 1), 8'(2 * mem_addr)};
      addr_log.push_back(mem_addr);
    end
  end

  // Engine: done pulse 5 cycles after eng_re when auto-respond is on
  always @(posedge clk) begin
    done_model <= 1'b0;
    if (eng_re) eng_log.push_back(eng_addr);
    if (eng_re && eng_auto) begin
      eng_cnt <= 4'd5;
    end else if (eng_cnt != 4'd0) begin
      eng_cnt <= eng_cnt - 4'd1;
      if (eng_cnt == 4'd1) done_model <= 1'b1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; spur_done = 1'b0; eng_auto = 1'b1;
    img_w = 8'd4; img_h = 8'd4; img_base = '0; shift_cfg = '0;
    eng_cnt = '0; done_model = 1'b0; done_cnt = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_err got %b/%b want 0/00", err, err_code); end
    checks++; if (tile_count !== 16'd0) begin errors++; $display("FAIL reset_tile_count got %h want 0", tile_count); end
    checks++; if (mem_re !== 1'b0 || mem_addr !== 16'd0) begin errors++; $display("FAIL reset_mem got %b/%h want 0/0", mem_re, mem_addr); end
    checks++; if (eng_re !== 1'b0 || eng_addr !== 16'd0 || eng_shift !== 2'd0) begin errors++; $display("FAIL reset_eng got %b/%h/%h want 0/0/0", eng_re, eng_addr, eng_shift); end
    checks++; if (eng_image !== 128'd0) begin errors++; $display("FAIL reset_eng_image got %h want 0", eng_image); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    int la, le, dc;
    bit seen;
    img_w = 8'd4; img_h = 8'd4; img_base = 16'h0100; shift_cfg = 2'b10; eng_auto = 1'b1;
    la = addr_log.size(); le = eng_log.size(); dc = done_cnt;
    start_frame();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    wait_done(200, seen);
    checks++; if (!seen) begin errors++; $display("FAIL single_done_timeout got no done want done"); end
    checks++; if (tile_count !== 16'd1) begin errors++; $display("FAIL single_tile_count got %0d want 1", tile_count); end
    checks++; if (eng_image !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin errors++; $display("FAIL single_pack got %h want 0f0e..0100", eng_image); end
    checks++; if (eng_shift !== 2'b10) begin errors++; $display("FAIL single_shift got %b want 10", eng_shift); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_after_done got busy %b done %b want 0 0", busy, done); end
    checks++; if (addr_log.size() - la !== 8) begin errors++; $display("FAIL single_nreads got %0d want 8", addr_log.size() - la); end
    for (int i = 0; i < 8 && la + i < addr_log.size(); i++) begin
      checks++; if (addr_log[la + i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL single_addr%0d got %h want %h", i, addr_log[la + i], 16'h0100 + 16'(i)); end
    end
    checks++; if (eng_log.size() - le !== 1) begin errors++; $display("FAIL single_n_eng_re got %0d want 1", eng_log.size() - le); end
    if (eng_log.size() > le) begin
      checks++; if (eng_log[le] !== 16'd0) begin errors++; $display("FAIL single_eng_addr got %h want 0", eng_log[le]); end
    end
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt - dc); end
  endtask

  task automatic test_frame_8x6();
    int la, le, dc;
    bit seen;
    int exp0[8] = '{0, 1, 4, 5, 8, 9, 12, 13};
    int exp1[8] = '{1, 2, 5, 6, 9, 10, 13, 14};
    int exp3[8] = '{8, 9, 12, 13, 16, 17, 20, 21};
    img_w = 8'd8; img_h = 8'd6; img_base = 16'h0000; shift_cfg = 2'b01;
    la = addr_log.size(); le = eng_log.size(); dc = done_cnt;
    start_frame();
    wait_done(600, seen);
    checks++; if (!seen) begin errors++; $display("FAIL frame_done_timeout got no done want done"); end
    checks++; if (tile_count !== 16'd6) begin errors++; $display("FAIL frame_tile_count got %0d want 6", tile_count); end
    repeat (5) @(negedge clk);
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", done_cnt - dc); end
    checks++; if (addr_log.size() - la !== 48) begin errors++; $display("FAIL frame_nreads got %0d want 48", addr_log.size() - la); end
    checks++; if (eng_log.size() - le !== 6) begin errors++; $display("FAIL frame_n_eng_re got %0d want 6", eng_log.size() - le); end
    if (addr_log.size() - la >= 48) begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (addr_log[la + i] !== 16'(exp0[i])) begin errors++; $display("FAIL frame_t0_addr%0d got %0d want %0d", i, addr_log[la + i], exp0[i]); end
        checks++; if (addr_log[la + 8 + i] !== 16'(exp1[i])) begin errors++; $display("FAIL frame_t1_addr%0d got %0d want %0d", i, addr_log[la + 8 + i], exp1[i]); end
        checks++; if (addr_log[la + 24 + i] !== 16'(exp3[i])) begin errors++; $display("FAIL frame_t3_addr%0d got %0d want %0d", i, addr_log[la + 24 + i], exp3[i]); end
      end
    end
    for (int i = 0; i < 6 && le + i < eng_log.size(); i++) begin
      checks++; if (eng_log[le + i] !== 16'(i)) begin errors++; $display("FAIL frame_eng_addr%0d got %0d want %0d", i, eng_log[le + i], i); end
    end
  endtask

  task automatic test_timeout();
    int dc, n;
    bit seen;
    img_w = 8'd4; img_h = 8'd4; img_base = 16'h0200; eng_auto = 1'b0;
    dc = done_cnt;
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (eng_re === 1'b1) seen = 1'b1; else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_no_eng_re got none want eng_re"); end
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin seen = 1'b1; n = i; end
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL timeout_latency got %0d want 65 cycles after eng_re", n); end
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL timeout_code got %b want 01", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
    checks++; if (done_cnt !== dc) begin errors++; $display("FAIL timeout_no_done got %0d pulses want 0", done_cnt - dc); end
    eng_auto = 1'b1;
    start_frame();
    checks++; if (err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL timeout_restart got err %b code %b busy %b want 0 00 1", err, err_code, busy); end
    wait_done(200, seen);
    checks++; if (!seen) begin errors++; $display("FAIL timeout_restart_done got no done want done"); end
  endtask

  task automatic test_bad_cfg();
    int la;
    bit re_seen;
    img_w = 8'd5; img_h = 8'd4; img_base = 16'h0000;
    la = addr_log.size();
    start_frame();
    checks++; if (err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL badcfg_err got %b/%b want 1/10", err, err_code); end
    re_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_re !== 1'b0 || busy !== 1'b0) re_seen = 1'b1;
    end
    checks++; if (re_seen) begin errors++; $display("FAIL badcfg_activity got mem_re/busy high want both 0"); end
    checks++; if (addr_log.size() !== la) begin errors++; $display("FAIL badcfg_reads got %0d want 0", addr_log.size() - la); end
  endtask

  task automatic test_abort();
    int la, le, dc;
    img_w = 8'd8; img_h = 8'd6; img_base = 16'h0000;
    la = addr_log.size(); le = eng_log.size(); dc = done_cnt;
    start_frame();
    checks++; if (mem_re !== 1'b1 || mem_addr !== 16'd0) begin errors++; $display("FAIL abort_k0 got %b/%h want 1/0000", mem_re, mem_addr); end
    repeat (3) @(negedge clk);
    checks++; if (mem_addr !== 16'd5) begin errors++; $display("FAIL abort_k3_addr got %0d want 5", mem_addr); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (mem_re !== 1'b0 || busy !== 1'b0 || eng_re !== 1'b0) begin errors++; $display("FAIL abort_stop got re %b busy %b eng_re %b want 0 0 0", mem_re, busy, eng_re); end
    repeat (30) @(negedge clk);
    checks++; if (eng_log.size() !== le) begin errors++; $display("FAIL abort_eng_re got %0d want 0", eng_log.size() - le); end
    checks++; if (done_cnt !== dc) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - dc); end
    checks++; if (addr_log.size() - la !== 4) begin errors++; $display("FAIL abort_nreads got %0d want 4", addr_log.size() - la); end
    checks++; if (tile_count !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL abort_hold got tc %0d err %b want 0 0", tile_count, err); end
  endtask

  task automatic test_ignored();
    int la, dc;
    bit seen, act;
    img_w = 8'd4; img_h = 8'd4; img_base = 16'h0300;
    la = addr_log.size(); dc = done_cnt;
    start_frame();
    repeat (2) @(negedge clk);
    img_w = 8'd8;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    img_w = 8'd4;
    wait_done(200, seen);
    checks++; if (!seen || tile_count !== 16'd1) begin errors++; $display("FAIL busy_start got done %b tc %0d want 1 1", seen, tile_count); end
    checks++; if (addr_log.size() - la !== 8) begin errors++; $display("FAIL busy_start_reads got %0d want 8", addr_log.size() - la); end
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    act = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || mem_re !== 1'b0 || done !== 1'b0) act = 1'b1;
    end
    checks++; if (act || tile_count !== 16'd1) begin errors++; $display("FAIL spurious_done got act %b tc %0d want 0 1", act, tile_count); end
    la = addr_log.size();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || addr_log.size() !== la) begin errors++; $display("FAIL abort_beats_start got busy %b reads %0d want 0 0", busy, addr_log.size() - la); end
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL ignored_done_count got %0d want 1", done_cnt - dc); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_frame_8x6();
    test_timeout();
    test_bad_cfg();
    test_abort();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
